// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions.
// Holds the IFM buffer command codes (ifm_read), the buffer mode codes and the
// state enum used by the IFM scan controller. No ports; imported by RTL files.
package cnn_pkg;

    // IFM buffer commands
    localparam logic [2:0] ALL       = 3'b111;  // load full 3x3 window
    localparam logic [2:0] RIGHT     = 3'b001;  // shift left, new right column
    localparam logic [2:0] DOWN      = 3'b010;  // shift up, new bottom row
    localparam logic [2:0] LEFT      = 3'b100;  // shift right, new left column
    localparam logic [2:0] NO_CHANGE = 3'b101;  // hold

    // IFM buffer modes
    localparam logic [1:0] CONVOL = 2'b01;
    localparam logic [1:0] FULLY  = 2'b10;
    localparam logic [1:0] POOL   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StWin,
        StDone
    } scan_state_e;

endpackage

// File: rtl/ifm_scan_ctrl.sv
// IFM scan controller: walks a 3x3 window over one convolution plane in a
// serpentine order (right along even window rows, left along odd ones).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, cfg_w, cfg_h   scan request and plane dimensions (sampled in idle)
//   busy, done, cfg_err   scan status; done/cfg_err are one-cycle pulses
//   fetch_req/ack/kind/row/col  fetch descriptor handshake to the IFM fetch unit
//   ifm_read, mode        command and mode to the IFM window buffer
//   win_valid/ack/row/col window handshake to the PE array
// All outputs are registered.
module ifm_scan_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_w,
    input  logic [DIM_W-1:0] cfg_h,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic [2:0]       fetch_kind,
    output logic [DIM_W-1:0] fetch_row,
    output logic [DIM_W-1:0] fetch_col,
    output logic [2:0]       ifm_read,
    output logic [1:0]       mode,
    output logic             win_valid,
    input  logic             win_ack,
    output logic [DIM_W-1:0] win_row,
    output logic [DIM_W-1:0] win_col
);

    localparam logic [DIM_W-1:0] One   = DIM_W'(1);
    localparam logic [DIM_W-1:0] Three = DIM_W'(3);

    scan_state_e      state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0] wr_q, wr_d, wc_q, wc_d;
    logic             dir_q, dir_d;  // 0: moving right, 1: moving left
    logic             err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic             fetch_req_q, fetch_req_d, win_valid_q, win_valid_d;
    logic [2:0]       fetch_kind_q, fetch_kind_d, ifm_read_q, ifm_read_d;
    logic [DIM_W-1:0] fetch_row_q, fetch_row_d, fetch_col_q, fetch_col_d;

    logic [DIM_W-1:0] last_col, last_row;
    logic             at_row_end, last_win;

    assign last_col   = w_q - Three;
    assign last_row   = h_q - Three;
    assign at_row_end = dir_q ? (wc_q == '0) : (wc_q == last_col);
    assign last_win   = (wr_q == last_row) && at_row_end;

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        h_d          = h_q;
        wr_d         = wr_q;
        wc_d         = wc_q;
        dir_d        = dir_q;
        err_d        = err_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        fetch_req_d  = 1'b0;
        win_valid_d  = 1'b0;
        ifm_read_d   = NO_CHANGE;
        fetch_kind_d = fetch_kind_q;
        fetch_row_d  = fetch_row_q;
        fetch_col_d  = fetch_col_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d          = cfg_w;
                    h_d          = cfg_h;
                    wr_d         = '0;
                    wc_d         = '0;
                    dir_d        = 1'b0;
                    busy_d       = 1'b1;
                    fetch_kind_d = ALL;
                    fetch_row_d  = '0;
                    fetch_col_d  = '0;
                    if ((cfg_w < Three) || (cfg_h < Three)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d       = 1'b0;
                        fetch_req_d = 1'b1;
                        state_d     = StFetch;
                    end
                end
            end
            StFetch: begin
                if (fetch_ack) begin
                    // Data lands on the buffer input next cycle; issue the command then.
                    ifm_read_d = fetch_kind_q;
                    state_d    = StLoad;
                end else begin
                    fetch_req_d = 1'b1;
                end
            end
            StLoad: begin
                win_valid_d = 1'b1;
                state_d     = StWin;
            end
            StWin: begin
                if (!win_ack) begin
                    win_valid_d = 1'b1;
                end else if (last_win) begin
                    state_d = StDone;
                end else begin
                    fetch_req_d = 1'b1;
                    state_d     = StFetch;
                    // Descriptor coordinates are relative to the window being left.
                    if (!dir_q && (wc_q != last_col)) begin
                        fetch_kind_d = RIGHT;
                        fetch_row_d  = wr_q;
                        fetch_col_d  = wc_q + Three;
                        wc_d         = wc_q + One;
                    end else if (dir_q && (wc_q != '0)) begin
                        fetch_kind_d = LEFT;
                        fetch_row_d  = wr_q;
                        fetch_col_d  = wc_q - One;
                        wc_d         = wc_q - One;
                    end else begin
                        fetch_kind_d = DOWN;
                        fetch_row_d  = wr_q + Three;
                        fetch_col_d  = wc_q;
                        wr_d         = wr_q + One;
                        dir_d        = ~dir_q;
                    end
                end
            end
            StDone: begin
                done_d    = 1'b1;
                cfg_err_d = err_q;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            w_q          <= '0;
            h_q          <= '0;
            wr_q         <= '0;
            wc_q         <= '0;
            dir_q        <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            fetch_req_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            ifm_read_q   <= NO_CHANGE;
            fetch_kind_q <= ALL;
            fetch_row_q  <= '0;
            fetch_col_q  <= '0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            wr_q         <= wr_d;
            wc_q         <= wc_d;
            dir_q        <= dir_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            fetch_req_q  <= fetch_req_d;
            win_valid_q  <= win_valid_d;
            ifm_read_q   <= ifm_read_d;
            fetch_kind_q <= fetch_kind_d;
            fetch_row_q  <= fetch_row_d;
            fetch_col_q  <= fetch_col_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign fetch_req  = fetch_req_q;
    assign fetch_kind = fetch_kind_q;
    assign fetch_row  = fetch_row_q;
    assign fetch_col  = fetch_col_q;
    assign ifm_read   = ifm_read_q;
    assign mode       = CONVOL;
    assign win_valid  = win_valid_q;
    assign win_row    = wr_q;
    assign win_col    = wc_q;

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// Self-checking bench for ifm_scan_ctrl: directed and random plane sizes with
// random handshake delays, checked against a serpentine window-list model.
module tb_ifm_scan_ctrl;
    import cnn_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_w = '0, cfg_h = '0;
    logic          busy, done, cfg_err, fetch_req, win_valid;
    logic          fetch_ack = 1'b0, win_ack = 1'b0;
    logic [2:0]    fetch_kind, ifm_read;
    logic [1:0]    mode;
    logic [DW-1:0] fetch_row, fetch_col, win_row, win_col;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ifm_scan_ctrl #(.DIM_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .fetch_kind (fetch_kind),
        .fetch_row  (fetch_row),
        .fetch_col  (fetch_col),
        .ifm_read   (ifm_read),
        .mode       (mode),
        .win_valid  (win_valid),
        .win_ack    (win_ack),
        .win_row    (win_row),
        .win_col    (win_col)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".busy"}, 32'(busy), 0);
        check_eq({tag, ".done"}, 32'(done), 0);
        check_eq({tag, ".cfg_err"}, 32'(cfg_err), 0);
        check_eq({tag, ".fetch_req"}, 32'(fetch_req), 0);
        check_eq({tag, ".win_valid"}, 32'(win_valid), 0);
        check_eq({tag, ".ifm_read"}, 32'(ifm_read), 32'(NO_CHANGE));
        check_eq({tag, ".mode"}, 32'(mode), 32'(CONVOL));
        check_eq({tag, ".fetch_kind"}, 32'(fetch_kind), 32'(ALL));
        check_eq({tag, ".fetch_rc"}, {fetch_row, fetch_col}, 0);
        check_eq({tag, ".win_rc"}, {win_row, win_col}, 0);
    endtask

    // Runs one scan from start to done (or aborts it with reset at window abort_win).
    // Delays: fixed ones when fixed=1, otherwise uniformly random in [0, max].
    task automatic run_scan(input int w, input int h, input int fd, input int wd,
                            input bit fixed, input int abort_win);
        int er[$], ec[$], fk[$], fr[$], fc[$];
        int cur_k, cur_r, cur_c, cur_wr, cur_wc;
        int fwait, wwait, nwin, budget;
        bit in_f, in_w, f_acc, finished, exp_err;
        logic [2:0] acc_kind;

        // Model: the ordered window list, then a fetch derived from each step.
        exp_err = (w < 3) || (h < 3);
        if (!exp_err) begin
            for (int r = 0; r <= h - 3; r++)
                for (int i = 0; i <= w - 3; i++) begin
                    er.push_back(r);
                    ec.push_back((r % 2 == 0) ? i : (w - 3 - i));
                end
            fk.push_back(ALL); fr.push_back(0); fc.push_back(0);
            for (int i = 1; i < er.size(); i++) begin
                if (er[i] > er[i-1]) begin
                    fk.push_back(DOWN);  fr.push_back(er[i-1] + 3); fc.push_back(ec[i-1]);
                end else if (ec[i] > ec[i-1]) begin
                    fk.push_back(RIGHT); fr.push_back(er[i-1]);     fc.push_back(ec[i-1] + 3);
                end else begin
                    fk.push_back(LEFT);  fr.push_back(er[i-1]);     fc.push_back(ec[i-1] - 1);
                end
            end
        end

        start = 1'b1;
        cfg_w = DW'(w);
        cfg_h = DW'(h);
        @(negedge clk);
        start = 1'b0;
        cfg_w = DW'($urandom);
        cfg_h = DW'($urandom);

        in_f = 0; in_w = 0; f_acc = 0; finished = 0; nwin = 0;
        fwait = 0; wwait = 0; acc_kind = NO_CHANGE;
        cur_k = 0; cur_r = 0; cur_c = 0; cur_wr = 0; cur_wc = 0;
        budget = 2000;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            check_eq("ifm_read", 32'(ifm_read), f_acc ? 32'(acc_kind) : 32'(NO_CHANGE));
            check_eq("mode", 32'(mode), 32'(CONVOL));
            f_acc = 0;
            start = ($urandom_range(0, 3) == 0);  // ignored while scanning
            if (done) begin
                start = 1'b0;
                check_eq("cfg_err_at_done", 32'(cfg_err), 32'(exp_err));
                check_eq("busy_at_done", 32'(busy), 0);
                check_eq("windows_left", er.size(), 0);
                check_eq("fetches_left", fk.size(), 0);
                if (exp_err) check_eq("err_latency", cyc, 2);
                fetch_ack = 1'b0;
                win_ack   = 1'b0;
                finished  = 1;
                break;
            end
            check_eq("busy", 32'(busy), 1);
            check_eq("cfg_err_low", 32'(cfg_err), 0);

            if (fetch_req) begin
                if (!in_f) begin
                    in_f = 1;
                    cur_k = -1; cur_r = -1; cur_c = -1;
                    if (fk.size() > 0) begin
                        cur_k = fk.pop_front(); cur_r = fr.pop_front(); cur_c = fc.pop_front();
                    end
                    fwait = fixed ? fd : $urandom_range(0, fd);
                end
                check_eq("fetch_kind", 32'(fetch_kind), cur_k);
                check_eq("fetch_row", 32'(fetch_row), cur_r);
                check_eq("fetch_col", 32'(fetch_col), cur_c);
                if (fwait == 0) begin
                    fetch_ack = 1'b1;
                    f_acc     = 1;
                    acc_kind  = fetch_kind;
                    in_f      = 0;
                end else begin
                    fetch_ack = 1'b0;
                    fwait--;
                end
            end else begin
                fetch_ack = 1'b0;
            end

            if (win_valid) begin
                if (!in_w) begin
                    in_w = 1;
                    cur_wr = -1; cur_wc = -1;
                    if (er.size() > 0) begin
                        cur_wr = er.pop_front(); cur_wc = ec.pop_front();
                    end
                    if (nwin == abort_win) begin
                        fetch_ack = 1'b0;
                        win_ack   = 1'b0;
                        start     = 1'b0;
                        #2 rst_n = 1'b0;
                        #1 check_reset_outputs("async_rst");
                        @(negedge clk);
                        check_reset_outputs("held_rst");
                        rst_n = 1'b1;
                        return;
                    end
                    nwin++;
                    wwait = fixed ? wd : $urandom_range(0, wd);
                end
                check_eq("win_row", 32'(win_row), cur_wr);
                check_eq("win_col", 32'(win_col), cur_wc);
                if (wwait == 0) begin
                    win_ack = 1'b1;
                    in_w    = 0;
                end else begin
                    win_ack = 1'b0;
                    wwait--;
                end
            end else begin
                win_ack = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("scan_finished", 32'(finished), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(5, 4, 0, 0, 1, -1);
        run_scan(3, 3, 0, 0, 1, -1);
        run_scan(3, 6, 0, 0, 1, -1);
        run_scan(5, 4, 4, 7, 1, -1);
        run_scan(2, 9, 0, 0, 1, -1);
        run_scan(4, 4, 1, 1, 1, 2);
        run_scan(4, 4, 0, 0, 1, -1);
        for (int i = 0; i < 12; i++) begin
            run_scan($urandom_range(1, 8), $urandom_range(2, 8),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
